// File: rtl/note_lane_scroller.sv
// Falling-note lane engine: chart injection, per-frame scroll, hit judgement and scoring.
// Optional NOTE_COMBO_EN adds a combo counter and a bonus for PERFECT hits on a streak.

module note_lane_scroller_lane #(
  parameter int ROWS     = 435,
  parameter int SPEED    = 2,
  parameter int HIT_TOP  = 410,
  parameter int PERF_TOP = 422
) (
  input  logic            clk25MHZ,
  input  logic            rst,
  input  logic            clr,
  input  logic            tick,
  input  logic            judge,
  input  logic [SPEED-1:0] inj,
  output logic [ROWS-1:0] col,
  output logic            perfect,
  output logic            good,
  output logic            miss,
  output logic            lost
);
  logic [ROWS-1:0] col_q, col_d;
  logic perf_zone, good_zone;

  assign perf_zone = |col_q[ROWS-1:PERF_TOP];
  assign good_zone = |col_q[PERF_TOP-1:HIT_TOP];
  assign perfect   = judge & perf_zone;
  assign good      = judge & ~perf_zone & good_zone;
  assign miss      = judge & ~perf_zone & ~good_zone;
  assign lost      = tick & (|col_q[ROWS-1 -: SPEED]);
  assign col       = col_q;

  always_comb begin
    col_d = col_q;
    if (clr)
      col_d = '0;
    else if (tick)
      col_d = {col_q[ROWS-1-SPEED:0], inj};
    else if (perfect | good)
      col_d[ROWS-1:HIT_TOP] = '0;
  end

  always_ff @(posedge clk25MHZ or negedge rst)
    if (!rst) col_q <= '0;
    else      col_q <= col_d;
endmodule

module note_lane_scroller #(
  parameter int ROWS        = 435,
  parameter int SPEED       = 2,
  parameter int NOTE_H      = 12,
  parameter int BEAT_FRAMES = 30,
  parameter int HIT_TOP     = 410,
  parameter int PERF_TOP    = 422
) (
  input  logic            clk25MHZ,
  input  logic            rst,
  input  logic            start,
  input  logic            vs,
  input  logic [3:0]      keys,
  output logic [9:0]      chart_addr,
  input  logic [4:0]      chart_data,
  output logic [ROWS-1:0] col1,
  output logic [ROWS-1:0] col2,
  output logic [ROWS-1:0] col3,
  output logic [ROWS-1:0] col4,
  output logic [3:0]      hits,
  output logic [2:0]      msg,
  output logic [15:0]     score,
  output logic            playing
`ifdef NOTE_COMBO_EN
  ,
  output logic [7:0]      combo
`endif
);
  localparam int NUM_LANES = 4;
  localparam int IW = $clog2(NOTE_H + 1);
  localparam int BW = $clog2(BEAT_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [9:0]    chart_addr_q, chart_addr_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0] inj_left_q, inj_left_d, inj_cnt;
  logic [NUM_LANES-1:0] inj_mask_q, inj_mask_d, inj_mask_eff;
  logic [NUM_LANES-1:0] press_pend_q, press_pend_d;
  logic [15:0]   score_q, score_d;
  logic [2:0]    msg_q, msg_d;
`ifdef NOTE_COMBO_EN
  logic [7:0]    combo_q, combo_d;
  logic [8:0]    combo_sum;
`endif

  logic [NUM_LANES-1:0] key_s1_q, key_s2_q, key_prev_q, key_edge;
  logic vs_s1_q, vs_s2_q, vs_prev_q, frame_tick;

  // Two-flop synchronisers; edges taken on the synchronised side.
  always_ff @(posedge clk25MHZ or negedge rst)
    if (!rst) begin
      key_s1_q <= '0; key_s2_q <= '0; key_prev_q <= '0;
      vs_s1_q  <= 1'b0; vs_s2_q <= 1'b0; vs_prev_q <= 1'b0;
    end else begin
      key_s1_q <= keys;    key_s2_q <= key_s1_q; key_prev_q <= key_s2_q;
      vs_s1_q  <= vs;      vs_s2_q  <= vs_s1_q;  vs_prev_q  <= vs_s2_q;
    end

  assign key_edge   = key_s2_q & ~key_prev_q;
  assign frame_tick = vs_s2_q & ~vs_prev_q;

  logic active, tick, beat, beat_inj, go;
  logic [SPEED-1:0] inj_bits;
  logic [NUM_LANES-1:0] judge, perfect, good, miss, lost;
  logic [NUM_LANES-1:0][ROWS-1:0] cols;

  assign active       = (state_q == S_PLAY) || (state_q == S_DRAIN);
  assign tick         = frame_tick & active;
  assign beat         = frame_tick & (state_q == S_PLAY) & (beat_cnt_q == BW'(BEAT_FRAMES - 1));
  assign beat_inj     = beat & ~chart_data[4];
  assign go           = start & ((state_q == S_IDLE) || (state_q == S_DONE));
  assign inj_cnt      = beat_inj ? IW'(NOTE_H) : inj_left_q;
  assign inj_mask_eff = beat_inj ? chart_data[3:0] : inj_mask_q;
  // A press landing on a tick is deferred so it sees the scrolled bitmap.
  assign judge        = {NUM_LANES{active & ~frame_tick}} & (key_edge | press_pend_q);

  always_comb begin
    inj_bits = '0;
    for (int j = 0; j < SPEED; j++) inj_bits[j] = (j < int'(inj_cnt));
  end

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      note_lane_scroller_lane #(
        .ROWS(ROWS), .SPEED(SPEED), .HIT_TOP(HIT_TOP), .PERF_TOP(PERF_TOP)
      ) u_lane (
        .clk25MHZ(clk25MHZ), .rst(rst), .clr(go), .tick(tick), .judge(judge[i]),
        .inj(inj_bits & {SPEED{inj_mask_eff[i]}}),
        .col(cols[i]), .perfect(perfect[i]), .good(good[i]), .miss(miss[i]), .lost(lost[i])
      );
    end
  endgenerate

  logic [3:0]  add;
  logic [3:0]  nhits;
  logic [17:0] score_sum;
  logic        any_miss;

  always_comb begin
    add   = '0;
    nhits = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (perfect[i]) begin
`ifdef NOTE_COMBO_EN
        add = add + ((combo_q >= 8'd10) ? 4'd3 : 4'd2);
`else
        add = add + 4'd2;
`endif
        nhits = nhits + 4'd1;
      end else if (good[i]) begin
        add   = add + 4'd1;
        nhits = nhits + 4'd1;
      end
    end
    score_sum = {2'b00, score_q} + 18'(add);
    any_miss  = (|miss) | (|lost);
  end

  always_comb begin
    state_d      = state_q;
    chart_addr_d = chart_addr_q;
    beat_cnt_d   = beat_cnt_q;
    inj_left_d   = inj_left_q;
    inj_mask_d   = inj_mask_q;
    press_pend_d = {NUM_LANES{tick}} & key_edge;
    score_d      = score_q;
    msg_d        = msg_q;
`ifdef NOTE_COMBO_EN
    combo_d      = combo_q;
    combo_sum    = {1'b0, combo_q} + 9'(nhits);
`endif
    case (state_q)
      S_IDLE, S_DONE: if (go) begin
        state_d      = S_PLAY;
        chart_addr_d = '0;
        beat_cnt_d   = '0;
        inj_left_d   = '0;
        inj_mask_d   = '0;
        score_d      = '0;
        msg_d        = 3'd0;
`ifdef NOTE_COMBO_EN
        combo_d      = '0;
`endif
      end
      default: if (frame_tick) begin
        inj_left_d = (inj_cnt > IW'(SPEED)) ? inj_cnt - IW'(SPEED) : '0;
        if (state_q == S_PLAY) begin
          beat_cnt_d = beat ? '0 : beat_cnt_q + BW'(1);
          if (beat && chart_data[4]) begin
            state_d = S_DRAIN;
          end else if (beat) begin
            inj_mask_d   = chart_data[3:0];
            chart_addr_d = chart_addr_q + 10'd1;
          end
        end else if (~|cols) begin
          state_d = S_DONE;
          msg_d   = 3'd4;
        end
      end
    endcase

    if (active) begin
      if (any_miss)     msg_d = 3'd3;
      else if (|good)   msg_d = 3'd2;
      else if (|perfect) msg_d = 3'd1;
      score_d = (|score_sum[17:16]) ? 16'hFFFF : score_sum[15:0];
`ifdef NOTE_COMBO_EN
      if (any_miss) combo_d = '0;
      else          combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
`endif
    end
  end

  always_ff @(posedge clk25MHZ or negedge rst)
    if (!rst) begin
      state_q      <= S_IDLE;
      chart_addr_q <= '0;
      beat_cnt_q   <= '0;
      inj_left_q   <= '0;
      inj_mask_q   <= '0;
      press_pend_q <= '0;
      score_q      <= '0;
      msg_q        <= '0;
`ifdef NOTE_COMBO_EN
      combo_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      chart_addr_q <= chart_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      inj_left_q   <= inj_left_d;
      inj_mask_q   <= inj_mask_d;
      press_pend_q <= press_pend_d;
      score_q      <= score_d;
      msg_q        <= msg_d;
`ifdef NOTE_COMBO_EN
      combo_q      <= combo_d;
`endif
    end

  assign chart_addr = chart_addr_q;
  assign col1       = cols[0];
  assign col2       = cols[1];
  assign col3       = cols[2];
  assign col4       = cols[3];
  assign hits       = key_s2_q;
  assign msg        = msg_q;
  assign score      = score_q;
  assign playing    = active;
`ifdef NOTE_COMBO_EN
  assign combo      = combo_q;
`endif
endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed bench: one short chart driven frame by frame, expected bitmaps and scores worked out by hand.
module tb_note_lane_scroller;
  localparam int ROWS = 435;

  logic clk25MHZ = 1'b0;
  logic rst = 1'b0, start = 1'b0, vs = 1'b0;
  logic [3:0] keys = 4'd0;
  logic [9:0] chart_addr;
  logic [4:0] chart_data = 5'd0;
  logic [ROWS-1:0] col1, col2, col3, col4;
  logic [3:0] hits;
  logic [2:0] msg;
  logic [15:0] score;
  logic playing;
`ifdef NOTE_COMBO_EN
  logic [7:0] combo;
`endif

  logic [4:0] chart_mem [0:1023];
  int n_chk = 0, n_err = 0, fr = 0;
  logic [ROWS-1:0] e;

  note_lane_scroller dut (
    .clk25MHZ(clk25MHZ), .rst(rst), .start(start), .vs(vs), .keys(keys),
    .chart_addr(chart_addr), .chart_data(chart_data),
    .col1(col1), .col2(col2), .col3(col3), .col4(col4),
    .hits(hits), .msg(msg), .score(score), .playing(playing)
`ifdef NOTE_COMBO_EN
    , .combo(combo)
`endif
  );

  always #20 clk25MHZ = ~clk25MHZ;
  always @(posedge clk25MHZ) chart_data <= chart_mem[chart_addr];

  task automatic chk(input string tag, input logic [ROWS-1:0] got, input logic [ROWS-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk25MHZ);
    #1;
  endtask

  // One frame: vs low then high; k rises together with vs so its edge meets the tick.
  task automatic frame(input logic [3:0] k);
    vs = 1'b0; cyc(3);
    vs = 1'b1; keys = k; cyc(4);
    fr++;
  endtask

  task automatic run_to(input int f);
    while (fr < f) frame(4'd0);
  endtask

  task automatic press(input string tag, input logic [3:0] k, input logic [2:0] m, input logic [15:0] s);
    keys = k; cyc(4);
    chk({tag, "_msg"}, ROWS'(msg), ROWS'(m));
    chk({tag, "_score"}, ROWS'(score), ROWS'(s));
    keys = 4'd0; cyc(3);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) chart_mem[i] = 5'd0;
    chart_mem[0] = 5'b00001;
    chart_mem[1] = 5'b00010;
    chart_mem[2] = 5'b00000;
    chart_mem[3] = 5'b01000;
    chart_mem[4] = 5'b10000;

    cyc(3);
    rst = 1'b1; cyc(2);
    chk("rst_cols", col1 | col2 | col3 | col4, '0);
    chk("rst_hits", ROWS'(hits), '0);
    chk("rst_msg", ROWS'(msg), '0);
    chk("rst_score", ROWS'(score), '0);
    chk("rst_addr", ROWS'(chart_addr), '0);
    chk("rst_playing", ROWS'(playing), '0);

    keys = 4'b0101; cyc(1);
    chk("hits_lag1", ROWS'(hits), '0);
    cyc(1);
    chk("hits_lag2", ROWS'(hits), ROWS'(4'b0101));
    keys = 4'd0; cyc(4);
    chk("idle_key_msg", ROWS'(msg), '0);

    start = 1'b1; cyc(1); start = 1'b0;
    chk("start_playing", ROWS'(playing), ROWS'(1));

    run_to(30);
    chk("inj_first", col1, ROWS'(2'b11));
    chk("inj_addr", ROWS'(chart_addr), ROWS'(1));
    chk("inj_lane2", col2, '0);
    run_to(35);
    chk("inj_full", col1, ROWS'(12'hFFF));

    run_to(150);
    chk("end_playing", ROWS'(playing), ROWS'(1));
    chk("end_noinj", ROWS'((col1 | col2 | col3 | col4) & ROWS'(2'b11)), '0);

    run_to(240);
    e = ROWS'(12'hFFF) << 410;
    chk("scroll_410", col1, e);
    run_to(246);
    e = ROWS'(12'hFFF) << 422;
    chk("scroll_422", col1, e);
    press("perfect", 4'b0001, 3'd1, 16'd2);
    chk("perfect_clr", col1, '0);

    run_to(270);
    e = ROWS'(12'hFFF) << 410;
    chk("good_pos", col2, e);
    press("good", 4'b0010, 3'd2, 16'd3);
    chk("good_clr", col2, '0);
    press("miss", 4'b0100, 3'd3, 16'd3);

    run_to(324);
    e = ROWS'(12'hFFF) << 398;
    chk("coll_pre", col4, e);
    frame(4'b1000);
    keys = 4'd0;
    chk("coll_msg", ROWS'(msg), ROWS'(2));
    chk("coll_score", ROWS'(score), ROWS'(4));
    e = ROWS'(10'h3FF) << 400;
    chk("coll_clr", col4, e);
    cyc(3);

    run_to(337);
    chk("missout_pre", ROWS'(msg), ROWS'(2));
    run_to(338);
    chk("missout", ROWS'(msg), ROWS'(3));
    run_to(343);
    chk("drain_playing", ROWS'(playing), ROWS'(1));
    run_to(344);
    chk("done_msg", ROWS'(msg), ROWS'(4));
    chk("done_playing", ROWS'(playing), '0);
    press("done_key", 4'b0001, 3'd4, 16'd4);

    start = 1'b1; cyc(1); start = 1'b0;
    chk("restart_playing", ROWS'(playing), ROWS'(1));
    chk("restart_score", ROWS'(score), '0);
    chk("restart_msg", ROWS'(msg), '0);
    chk("restart_addr", ROWS'(chart_addr), '0);

    fr = 0;
    run_to(31);
    chk("replay_inj", col1, ROWS'(4'hF));
    rst = 1'b0; cyc(1);
    chk("midrst_cols", col1 | col2 | col3 | col4, '0);
    chk("midrst_playing", ROWS'(playing), '0);
    chk("midrst_msg", ROWS'(msg), '0);
    chk("midrst_score", ROWS'(score), '0);
    rst = 1'b1; cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
